// File: rtl/regwr_arbiter.sv
// Round-robin arbiter merging the ALU result path (A) and load path (B) onto
// the single write port of the 16-entry register group.
module regwr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  a_valid,
  input  logic [IDX_WIDTH-1:0]  a_ind,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [IDX_WIDTH-1:0]  b_ind,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  wr_en,
  output logic [IDX_WIDTH-1:0]  wr_ind,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  idx_err,
  input  logic                  err_clr
);

  localparam int unsigned SEL_WIDTH = 4;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]  ind;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  last_e                 last_q, last_d;
  logic                  grant_a, grant_b;
  wr_req_t               sel_req;
  logic                  sel_oor;
  logic                  wr_en_d;
  logic [IDX_WIDTH-1:0]  wr_ind_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  idx_err_d;

  // Grant decision: never depends on the requesters' payload, only on valid and pointer
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst && !stall) begin
      if (a_valid && b_valid) begin
        if (last_q == LAST_B) grant_a = 1'b1;
        else                  grant_b = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Payload of whichever requester was granted
  always_comb begin
    sel_req.ind  = b_ind;
    sel_req.data = b_data;
    if (grant_a) begin
      sel_req.ind  = a_ind;
      sel_req.data = a_data;
    end
    sel_oor = (sel_req.ind >> SEL_WIDTH) != IDX_WIDTH'(0);
  end

  // Next-state: pointer, write port and sticky error
  always_comb begin
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_ind_d  = wr_ind;
    wr_data_d = wr_data;
    idx_err_d = idx_err;
    if (err_clr) idx_err_d = 1'b0;
    if (grant_a || grant_b) begin
      last_d    = grant_a ? LAST_A : LAST_B;
      wr_ind_d  = sel_req.ind;
      wr_data_d = sel_req.data;
      // An out-of-range index is dropped from the decoder and flagged; set beats clear
      if (sel_oor) idx_err_d = 1'b1;
      else         wr_en_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q  <= LAST_B;
      wr_en   <= 1'b0;
      wr_ind  <= '0;
      wr_data <= '0;
      idx_err <= 1'b0;
    end else begin
      last_q  <= last_d;
      wr_en   <= wr_en_d;
      wr_ind  <= wr_ind_d;
      wr_data <= wr_data_d;
      idx_err <= idx_err_d;
    end
  end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Scoreboard bench for regwr_arbiter: directed scenarios followed by random
// traffic, checked against a request-level reference model.
module tb_regwr_arbiter;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       a_valid, b_valid;
  logic [7:0] a_ind, b_ind, a_data, b_data;
  logic       a_ready, b_ready;
  logic       wr_en;
  logic [7:0] wr_ind, wr_data;
  logic       idx_err;
  logic       err_clr;

  regwr_arbiter #(.DATA_WIDTH(8), .IDX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .a_valid(a_valid), .a_ind(a_ind), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_ind(b_ind), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_ind(wr_ind), .wr_data(wr_data),
    .idx_err(idx_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] ind;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;

  // Reference state: who was served last, what the write port holds, error flag
  bit       m_last_a;
  logic [7:0] m_ind, m_data;
  logic     m_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: one expected write-port record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          check("wr_en",   {31'd0, wr_en},   {31'd0, e.en});
          check("wr_ind",  {24'd0, wr_ind},  {24'd0, e.ind});
          check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
          check("idx_err", {31'd0, idx_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Apply one cycle of stimulus, check grants, predict the write-port result
  task automatic cycle(input logic r, input logic st, input logic clr,
                       input logic av, input logic [7:0] ai, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bi, input logic [7:0] bd,
                       output logic ga, output logic gb);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; err_clr = clr;
    a_valid = av; a_ind = ai; a_data = ad;
    b_valid = bv; b_ind = bi; b_data = bd;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (r && !st) begin
      if (av && bv) begin
        ga = !m_last_a;
        gb = m_last_a;
      end else begin
        ga = av;
        gb = bv;
      end
    end
    check("a_ready", {31'd0, a_ready}, {31'd0, ga});
    check("b_ready", {31'd0, b_ready}, {31'd0, gb});
    e.en = 1'b0;
    if (!r) begin
      m_last_a = 1'b0;
      m_ind = 8'd0;
      m_data = 8'd0;
      m_err = 1'b0;
    end else begin
      if (clr) m_err = 1'b0;
      if (ga || gb) begin
        m_last_a = ga;
        m_ind  = ga ? ai : bi;
        m_data = ga ? ad : bd;
        if (m_ind > 8'd15) m_err = 1'b1;
        else               e.en = 1'b1;
      end
    end
    e.ind = m_ind;
    e.data = m_data;
    e.err = m_err;
    q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    logic ga, gb;
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, ga, gb);
  endtask

  initial begin
    logic ga, gb;
    logic       pa_v, pb_v;
    logic [7:0] pa_i, pa_d, pb_i, pb_d;
    logic       r, st, clr;

    rst = 0; stall = 0; err_clr = 0;
    a_valid = 0; b_valid = 0; a_ind = 0; b_ind = 0; a_data = 0; b_data = 0;
    m_last_a = 0; m_ind = 0; m_data = 0; m_err = 0;

    // Reset then idle
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, ga, gb);
    idle(2);

    // Single requester
    cycle(1, 0, 0, 1, 8'h05, 8'h3C, 0, 8'h00, 8'h00, ga, gb);
    idle(2);

    // Contention from reset: A,B,A,B
    cycle(0, 0, 0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22, ga, gb);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22, ga, gb);
      check("contention_order", {31'd0, ga}, {31'd0, ~i[0]});
    end

    // Stall after an A grant; B must be first afterwards
    cycle(1, 0, 0, 1, 8'h03, 8'h33, 1, 8'h04, 8'h44, ga, gb);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 8'h06, 8'h66, 1, 8'h04, 8'h44, ga, gb);
    cycle(1, 0, 0, 1, 8'h06, 8'h66, 1, 8'h04, 8'h44, ga, gb);
    check("stall_resume_b", {31'd0, gb}, 32'd1);
    idle(1);

    // Index error, set-beats-clear, then clear alone
    cycle(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h13, 8'h5A, ga, gb);
    idle(1);
    cycle(1, 0, 1, 1, 8'h20, 8'h77, 0, 8'h00, 8'h00, ga, gb);
    cycle(1, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, ga, gb);
    idle(1);

    // Reset in the middle of a grant sequence
    cycle(1, 0, 0, 1, 8'h07, 8'h70, 1, 8'h08, 8'h80, ga, gb);
    cycle(1, 0, 0, 1, 8'h09, 8'h90, 1, 8'h08, 8'h80, ga, gb);
    cycle(0, 0, 0, 1, 8'h09, 8'h90, 1, 8'h0A, 8'hA0, ga, gb);
    cycle(1, 0, 0, 1, 8'h09, 8'h90, 1, 8'h0A, 8'hA0, ga, gb);
    check("post_reset_a_first", {31'd0, ga}, 32'd1);
    idle(1);

    // Random traffic; requesters hold their request until accepted
    pa_v = 0; pb_v = 0; pa_i = 0; pa_d = 0; pb_i = 0; pb_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa_v && ($urandom_range(0, 3) != 0)) begin
        pa_v = 1;
        pa_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        pa_d = 8'($urandom);
      end
      if (!pb_v && ($urandom_range(0, 3) != 0)) begin
        pb_v = 1;
        pb_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        pb_d = 8'($urandom);
      end
      r   = ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 4) == 0);
      clr = ($urandom_range(0, 7) == 0);
      cycle(r, st, clr, pa_v, pa_i, pa_d, pb_v, pb_i, pb_d, ga, gb);
      if (ga) pa_v = 0;
      if (gb) pb_v = 0;
    end
    idle(2);

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regwr_arbiter.md
Name: regwr_arbiter

Overview:
- Arbitrates two write requesters onto the single write port of the 16-entry register group.
  - Requester A is the ALU result path.
  - Requester B is the load path.
- Each requester uses a valid/ready handshake.
- One request is granted per cycle, round-robin.
- The granted write is registered and presented as index (wr_ind), enable (wr_en) and data.
- wr_ind and wr_en drive the register group's 4-to-16 index decoder directly. Only the low 4 index bits are meaningful.

Parameters:
- DATA_WIDTH, 8, width of register write data.
- IDX_WIDTH, 8, width of index buses; bits [3:0] select the register, bits above must be zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- stall  input  1  when high, no grants are issued this cycle.
- a_valid  input  1  requester A has a write pending.
- a_ind  input  IDX_WIDTH  requester A target register index.
- a_data  input  DATA_WIDTH  requester A write data.
- a_ready  output  1  requester A granted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_ind  input  IDX_WIDTH  requester B target register index.
- b_data  input  DATA_WIDTH  requester B write data.
- b_ready  output  1  requester B granted this cycle (combinational).
- wr_en  output  1  registered write strobe to the decoder En input.
- wr_ind  output  IDX_WIDTH  registered write index to the decoder Ind input.
- wr_data  output  DATA_WIDTH  registered write data to the register group.
- idx_err  output  1  sticky flag: an accepted request had a nonzero index bit above bit 3.
- err_clr  input  1  clears idx_err.

Behaviour:
- Reset (rst=0 at the clock edge):
  - wr_en=0, wr_ind=0, wr_data=0, idx_err=0.
  - Round-robin pointer last=B, so A wins the first tie.
  - a_ready and b_ready are forced to 0 while rst=0.
  - A transfer offered during the reset cycle is not accepted and is lost by design.
- Grant logic (combinational, when rst=1 and stall=0):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: the requester not equal to last gets ready.
  - Neither valid: both ready=0.
  - a_ready and b_ready are never high together.
  - ready does not depend on the requester's own data or index.
- stall=1: a_ready=b_ready=0. On the next edge wr_en becomes 0. The pointer and idx_err are unchanged.
- Transfer occurs when valid&&ready at a rising edge. On the next edge:
  - wr_ind <= granted ind; wr_data <= granted data; last <= granted requester.
  - wr_en <= 1 if granted ind[IDX_WIDTH-1:4]==0, else wr_en <= 0 and idx_err <= 1.
- Latency: an accepted request appears on wr_* exactly one cycle after the handshake edge, with wr_en high for exactly one cycle per transfer.
- No transfer in a cycle: wr_en <= 0. wr_ind and wr_data hold their last value.
- Throughput: one write per cycle. When both requesters are held valid, grants strictly alternate A,B,A,B.
- The pointer updates only on an actual transfer. Idle and stall cycles do not change fairness order.
- Requesters must hold valid, ind and data stable until accepted. The arbiter does not check this.
- Back-to-back writes to the same index are allowed; the later write wins. No hazard tracking is performed.
- err_clr:
  - err_clr=1 clears idx_err on the edge.
  - If an out-of-range transfer is accepted in the same cycle, set wins and idx_err=1.
- Data is passed unmodified; no width conversion.

Test Plan:
- Reset then idle:
  - rst=0 for 2 cycles, then rst=1 with a_valid=b_valid=0.
  - Required: wr_en=0, wr_ind=0, wr_data=0, idx_err=0, a_ready=b_ready=0.
- Single requester:
  - a_valid=1, a_ind=5, a_data=0x3C for one cycle.
  - Required: a_ready=1 that cycle; next cycle wr_en=1, wr_ind=5, wr_data=0x3C; the cycle after, wr_en=0 with wr_ind still 5.
- Contention:
  - Both valid for 4 cycles (A ind=1, data=0x11; B ind=2, data=0x22), starting from reset.
  - Required: grant order A,B,A,B; wr_ind sequence 1,2,1,2, lagging by one cycle.
- Stall:
  - Both valid, stall=1 for 3 cycles after an A grant, then stall=0.
  - Required: no ready and wr_en=0 during the stall; first grant after the stall goes to B.
- Index error:
  - b_valid=1, b_ind=0x13.
  - Required: b_ready=1; next cycle wr_en=0, idx_err=1.
  - Then assert err_clr with an a_ind=0x20 transfer in the same cycle. Required: idx_err stays 1. Then err_clr alone clears it to 0.
- Reset mid-operation:
  - Both valid, assert rst=0 for one cycle during a grant sequence.
  - Required: ready=0 during reset, wr_en=0 the next cycle, and A wins the first tie after reset.
